vdp_video_output: RTL and testbench

Converts the VDP's native pixel stream into a progressive 31.4 kHz display raster. It sits between the VDP colour pipeline and the display serializer. Each 2736-clock half-line of VDP pixels is captured into a double-banked line buffer. On the following line the buffer is horizontally resampled from 576 to 640 pixels with linear interpolation, and the block emits sync, data-enable and RGB. Optional scanline dimming is applied per line.

---
 rtl/vdp_video_output.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_vdp_video_output.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vdp_video_output.sv
// vdp_video_output
//   Converts the VDP native pixel stream into a progressive 31.4 kHz raster.
//   Each half-line (2736 clocks) of VDP pixels (576 per line) is captured into
//   a double-banked line buffer; the other bank is read back on the same line,
//   resampled from 576 to 640 pixels by linear interpolation and emitted with
//   sync, data enable and RGB through a 4-stage registered pipeline.
//
// Configuration macro:
//   VDP_VIDEO_OUT_SCANLINE_EN - when defined, has_scanline dims the output
//                               line (c - c/4); otherwise has_scanline is ignored.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   h_count[11:0]           horizontal position 0..2735
//   v_count[9:0]            output line number 0..524
//   has_scanline            dim the line currently being output
//   vdp_r/g/b[7:0]          VDP pixel colour
//   reg_denominator[7:0]    resampler modulus (clamped to >= 181)
//   reg_normalize[7:0]      fraction-to-weight scale
//   display_hs/vs           active-low syncs (registered)
//   display_en              data enable (registered)
//   display_r/g/b[7:0]      output pixel colour (registered)
module vdp_video_output (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] h_count,
  input  logic [9:0]  v_count,
  input  logic        has_scanline,
  input  logic [7:0]  vdp_r,
  input  logic [7:0]  vdp_g,
  input  logic [7:0]  vdp_b,
  output logic        display_hs,
  output logic        display_vs,
  output logic        display_en,
  output logic [7:0]  display_r,
  output logic [7:0]  display_g,
  output logic [7:0]  display_b,
  input  logic [7:0]  reg_denominator,
  input  logic [7:0]  reg_normalize
);

  localparam int unsigned IN_PIX    = 576;
  localparam int unsigned OUT_PIX   = 640;
  localparam int unsigned STEP      = 180;
  localparam int unsigned HALF      = IN_PIX / 2;
  localparam int unsigned POS_MAX   = IN_PIX - 1;
  localparam int unsigned CAP_END   = IN_PIX * 4;
  localparam int unsigned ACT_START = 160;
  localparam int unsigned ACT_END   = ACT_START + OUT_PIX * 4;
  localparam int unsigned HS_END    = 128;
  localparam int unsigned VS_FIRST  = 491;
  localparam int unsigned VS_LAST   = 492;
  localparam int unsigned V_FIRST   = 1;
  localparam int unsigned V_LAST    = 480;
  localparam int unsigned DEN_MIN   = 181;

  // Line buffer: even/odd split so P[k] and P[k+1] come from different arrays.
  logic [23:0] mem_even [0:1][0:HALF-1];
  logic [23:0] mem_odd  [0:1][0:HALF-1];

  // Resampler state
  logic [9:0]  pos_q, pos_d;
  logic [8:0]  frac_q, frac_d;
  logic [7:0]  den_q, den_d;
  logic        run_q, run_d;

  // Stage 1: fetched pixel pair, weight, sync
  logic [23:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [7:0]  s1_w_q, s1_w_d;
  logic        s1_dim_q, s1_dim_d;
  logic        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_en_q, s1_en_d;

  // Stage 2: interpolated colour
  logic [23:0] s2_rgb_q, s2_rgb_d;
  logic        s2_dim_q, s2_dim_d;
  logic        s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d, s2_en_q, s2_en_d;

  // Stage 3: dimmed colour
  logic [23:0] s3_rgb_q, s3_rgb_d;
  logic        s3_hs_q, s3_hs_d, s3_vs_q, s3_vs_d, s3_en_q, s3_en_d;

  // Stage 4: output registers
  logic [23:0] out_rgb_q, out_rgb_d;
  logic        out_hs_q, out_hs_d, out_vs_q, out_vs_d, out_en_q, out_en_d;

  // Stage-0 combinational signals
  logic        cap_we;
  logic [9:0]  cap_idx;
  logic        cap_bank;
  logic        rd_bank;
  logic        line_start;
  logic        strobe;
  logic [7:0]  den_sel;
  logic [7:0]  den_cur;
  logic [9:0]  pos_cur;
  logic [9:0]  pos_nxt;
  logic [8:0]  frac_cur;
  logic [8:0]  frac_sum;
  logic        frac_wrap;
  logic [16:0] prod;
  logic [11:0] wsh;
  logic [7:0]  weight;
  logic [8:0]  even_addr;
  logic [8:0]  odd_addr;
  logic [23:0] even_word;
  logic [23:0] odd_word;
  logic [23:0] pix_a;
  logic [23:0] pix_b;
  logic        hs_raw, vs_raw, en_raw;

  // Linear blend of two 8-bit samples with an 8-bit weight toward b.
  function automatic logic [7:0] lerp(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] w);
    logic [16:0] acc;
    acc = 17'(a) * 17'(9'd256 - 9'(w)) + 17'(b) * 17'(w);
    return 8'(acc >> 8);
  endfunction

  // Scanline attenuation to roughly 3/4 intensity.
  function automatic logic [7:0] dim(input logic [7:0] c);
    return 8'(c - (c >> 2));
  endfunction

  // Capture, readout addressing, resampler step and raw sync generation.
  always_comb begin
    cap_we     = (h_count[1:0] == 2'd3) && (h_count < 12'(CAP_END));
    cap_idx    = h_count[11:2];
    cap_bank   = v_count[0];
    rd_bank    = ~v_count[0];
    line_start = (h_count == 12'(ACT_START));
    strobe     = (h_count[1:0] == 2'd0) && (h_count >= 12'(ACT_START)) &&
                 (h_count < 12'(ACT_END));

    den_sel  = (reg_denominator < 8'(DEN_MIN)) ? 8'(DEN_MIN) : reg_denominator;
    den_cur  = line_start ? den_sel : den_q;
    pos_cur  = line_start ? 10'd0 : pos_q;
    frac_cur = line_start ? 9'd0 : frac_q;
    pos_nxt  = (pos_cur == 10'(POS_MAX)) ? pos_cur : pos_cur + 10'd1;

    prod   = 17'(frac_cur) * 17'(reg_normalize);
    wsh    = 12'(prod >> 5);
    weight = (wsh > 12'd255) ? 8'hFF : wsh[7:0];

    frac_sum  = frac_cur + 9'(STEP);
    frac_wrap = (frac_sum >= 9'(den_cur));

    // Odd pos pairs odd[k] with even[k+1]; at the last pixel the pair is clamped.
    odd_addr  = pos_cur[9:1];
    even_addr = pos_cur[9:1];
    if (pos_cur[0] && (pos_cur != 10'(POS_MAX))) begin
      even_addr = pos_cur[9:1] + 9'd1;
    end
    even_word = mem_even[rd_bank][even_addr];
    odd_word  = mem_odd[rd_bank][odd_addr];
    if (!pos_cur[0]) begin
      pix_a = even_word;
      pix_b = odd_word;
    end else begin
      pix_a = odd_word;
      pix_b = (pos_cur == 10'(POS_MAX)) ? odd_word : even_word;
    end

    hs_raw = !(h_count < 12'(HS_END));
    vs_raw = !((v_count == 10'(VS_FIRST)) || (v_count == 10'(VS_LAST)));
    en_raw = (h_count >= 12'(ACT_START)) && (h_count < 12'(ACT_END)) &&
             (v_count >= 10'(V_FIRST)) && (v_count <= 10'(V_LAST));
  end

  // Next-state for resampler state and all pipeline stages.
  always_comb begin
    pos_d     = pos_q;
    frac_d    = frac_q;
    den_d     = den_q;
    run_d     = run_q | line_start;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_w_d    = s1_w_q;
    s1_dim_d  = s1_dim_q;

    if (line_start) begin
      den_d = den_sel;
    end
    if (strobe) begin
      frac_d   = frac_wrap ? frac_sum - 9'(den_cur) : frac_sum;
      pos_d    = frac_wrap ? pos_nxt : pos_cur;
      s1_a_d   = pix_a;
      s1_b_d   = pix_b;
      s1_w_d   = weight;
      s1_dim_d = has_scanline;
    end
    s1_hs_d = hs_raw;
    s1_vs_d = vs_raw;
    s1_en_d = en_raw && run_d;

    s2_rgb_d = {lerp(s1_a_q[23:16], s1_b_q[23:16], s1_w_q),
                lerp(s1_a_q[15:8],  s1_b_q[15:8],  s1_w_q),
                lerp(s1_a_q[7:0],   s1_b_q[7:0],   s1_w_q)};
    s2_dim_d = s1_dim_q;
    s2_hs_d  = s1_hs_q;
    s2_vs_d  = s1_vs_q;
    s2_en_d  = s1_en_q;

`ifdef VDP_VIDEO_OUT_SCANLINE_EN
    s3_rgb_d = s2_dim_q ? {dim(s2_rgb_q[23:16]), dim(s2_rgb_q[15:8]), dim(s2_rgb_q[7:0])}
                        : s2_rgb_q;
`else
    s3_rgb_d = s2_rgb_q;
`endif
    s3_hs_d = s2_hs_q;
    s3_vs_d = s2_vs_q;
    s3_en_d = s2_en_q;

    // Blanking forces black whenever enable is low.
    out_rgb_d = s3_en_q ? s3_rgb_q : 24'h0;
    out_hs_d  = s3_hs_q;
    out_vs_d  = s3_vs_q;
    out_en_d  = s3_en_q;
  end

`ifndef VDP_VIDEO_OUT_SCANLINE_EN
  logic unused_dim;
  assign unused_dim = s2_dim_q ^ (dim(8'h0) == 8'h0);
`endif

  // Line buffer write port (contents are intentionally not reset).
  always_ff @(posedge clk) begin
    if (cap_we) begin
      if (cap_idx[0]) begin
        mem_odd[cap_bank][cap_idx[9:1]] <= {vdp_r, vdp_g, vdp_b};
      end else begin
        mem_even[cap_bank][cap_idx[9:1]] <= {vdp_r, vdp_g, vdp_b};
      end
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q     <= 10'd0;
      frac_q    <= 9'd0;
      den_q     <= 8'(DEN_MIN);
      run_q     <= 1'b0;
      s1_a_q    <= 24'h0;
      s1_b_q    <= 24'h0;
      s1_w_q    <= 8'h0;
      s1_dim_q  <= 1'b0;
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
      s1_en_q   <= 1'b0;
      s2_rgb_q  <= 24'h0;
      s2_dim_q  <= 1'b0;
      s2_hs_q   <= 1'b1;
      s2_vs_q   <= 1'b1;
      s2_en_q   <= 1'b0;
      s3_rgb_q  <= 24'h0;
      s3_hs_q   <= 1'b1;
      s3_vs_q   <= 1'b1;
      s3_en_q   <= 1'b0;
      out_rgb_q <= 24'h0;
      out_hs_q  <= 1'b1;
      out_vs_q  <= 1'b1;
      out_en_q  <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      frac_q    <= frac_d;
      den_q     <= den_d;
      run_q     <= run_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_w_q    <= s1_w_d;
      s1_dim_q  <= s1_dim_d;
      s1_hs_q   <= s1_hs_d;
      s1_vs_q   <= s1_vs_d;
      s1_en_q   <= s1_en_d;
      s2_rgb_q  <= s2_rgb_d;
      s2_dim_q  <= s2_dim_d;
      s2_hs_q   <= s2_hs_d;
      s2_vs_q   <= s2_vs_d;
      s2_en_q   <= s2_en_d;
      s3_rgb_q  <= s3_rgb_d;
      s3_hs_q   <= s3_hs_d;
      s3_vs_q   <= s3_vs_d;
      s3_en_q   <= s3_en_d;
      out_rgb_q <= out_rgb_d;
      out_hs_q  <= out_hs_d;
      out_vs_q  <= out_vs_d;
      out_en_q  <= out_en_d;
    end
  end

  assign display_hs = out_hs_q;
  assign display_vs = out_vs_q;
  assign display_en = out_en_q;
  assign display_r  = out_rgb_q[23:16];
  assign display_g  = out_rgb_q[15:8];
  assign display_b  = out_rgb_q[7:0];

endmodule

// File: tb/tb_vdp_video_output.sv
// tb_vdp_video_output
//   Directed bench for vdp_video_output: reset values, sync/enable widths,
//   uniform pass-through, interpolation, end clamp, denominator clamp,
//   scanline dimming, VS lines and mid-line reset.
module tb_vdp_video_output;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] h_count;
  logic [9:0]  v_count;
  logic        has_scanline;
  logic [7:0]  vdp_r, vdp_g, vdp_b;
  logic        display_hs, display_vs, display_en;
  logic [7:0]  display_r, display_g, display_b;
  logic [7:0]  reg_denominator, reg_normalize;

  always #5 clk = ~clk;

  vdp_video_output dut (
    .clk             (clk),
    .reset           (reset),
    .h_count         (h_count),
    .v_count         (v_count),
    .has_scanline    (has_scanline),
    .vdp_r           (vdp_r),
    .vdp_g           (vdp_g),
    .vdp_b           (vdp_b),
    .display_hs      (display_hs),
    .display_vs      (display_vs),
    .display_en      (display_en),
    .display_r       (display_r),
    .display_g       (display_g),
    .display_b       (display_b),
    .reg_denominator (reg_denominator),
    .reg_normalize   (reg_normalize)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] pix [0:639];
  int hs_low_cnt, en_cnt, en_first, hold_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one line (h = 0..stop_h-1); outputs sampled at each negedge belong
  // to the h driven four clocks earlier.
  task automatic run_line(input int v, input int mode, input logic [23:0] col,
                          input logic scan, input int stop_h);
    hs_low_cnt = 0;
    en_cnt     = 0;
    en_first   = -1;
    hold_err   = 0;
    for (int h = 0; h < stop_h; h++) begin
      logic [23:0] rgb;
      logic [23:0] px;
      int oh;
      int k;
      @(negedge clk);
      if (h >= 4) begin
        oh  = h - 4;
        rgb = {display_r, display_g, display_b};
        if (!display_hs) hs_low_cnt++;
        if (display_en) begin
          en_cnt++;
          if (en_first < 0) en_first = oh;
        end
        if (oh >= 160 && oh < 2720) begin
          k = (oh - 160) / 4;
          if (((oh - 160) % 4) == 0) pix[k] = rgb;
          else if (rgb !== pix[k]) hold_err++;
        end
      end
      h_count      = 12'(h);
      v_count      = 10'(v);
      has_scanline = scan;
      if (mode == 0) px = col;
      else px = (((h >> 2) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      {vdp_r, vdp_g, vdp_b} = px;
    end
  endtask

  // Short burst on line v; the final sample corresponds to h=4 of that line.
  task automatic vs_probe(input int v, input logic exp_vs);
    for (int h = 0; h < 8; h++) begin
      @(negedge clk);
      h_count = 12'(h);
      v_count = 10'(v);
    end
    @(negedge clk);
    check($sformatf("vs_line%0d", v), 32'(display_vs), 32'(exp_vs));
  endtask

  function automatic int count_not(input logic [23:0] c);
    int n = 0;
    for (int i = 0; i < 640; i++) if (pix[i] !== c) n++;
    return n;
  endfunction

  logic [23:0] scan_exp;

  initial begin
`ifdef VDP_VIDEO_OUT_SCANLINE_EN
    scan_exp = 24'hBD6030;
`else
    scan_exp = 24'hFC8040;
`endif
    reset           = 1'b1;
    h_count         = 12'd0;
    v_count         = 10'd0;
    has_scanline    = 1'b0;
    {vdp_r, vdp_g, vdp_b} = 24'h0;
    reg_denominator = 8'd200;
    reg_normalize   = 8'd41;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hs", 32'(display_hs), 32'd1);
    check("rst_vs", 32'(display_vs), 32'd1);
    check("rst_en", 32'(display_en), 32'd0);
    check("rst_rgb", 32'({display_r, display_g, display_b}), 32'h0);
    reset = 1'b0;

    // Line 0: capture uniform colour, no enable on line 0.
    run_line(0, 0, 24'hFF8040, 1'b0, 2736);
    check("l0_hs_low", 32'(hs_low_cnt), 32'd128);
    check("l0_en_cnt", 32'(en_cnt), 32'd0);

    // Line 1: display the uniform line; capture alternating 00/FF.
    run_line(1, 1, 24'h0, 1'b0, 2736);
    check("l1_hs_low", 32'(hs_low_cnt), 32'd128);
    check("l1_en_cnt", 32'(en_cnt), 32'd2560);
    check("l1_en_first", 32'(en_first), 32'd160);
    check("l1_pix0", 32'(pix[0]), 32'hFF8040);
    check("l1_pix639", 32'(pix[639]), 32'hFF8040);
    check("l1_uniform_bad", 32'(count_not(24'hFF8040)), 32'd0);
    check("l1_hold_err", 32'(hold_err), 32'd0);

    // Line 2: interpolation of alternating input; capture FC/80/40.
    run_line(2, 0, 24'hFC8040, 1'b0, 2736);
    check("l2_pix0", 32'(pix[0]), 32'h000000);
    check("l2_pix1", 32'(pix[1]), 32'hE5E5E5);
    check("l2_pix2", 32'(pix[2]), 32'h323232);
    check("l2_pix639", 32'(pix[639]), 32'hFFFFFF);
    check("l2_hold_err", 32'(hold_err), 32'd0);

    // Line 3: scanline dimming on uniform line; capture alternating.
    run_line(3, 1, 24'h0, 1'b1, 2736);
    check("l3_scan_pix0", 32'(pix[0]), 32'(scan_exp));
    check("l3_scan_bad", 32'(count_not(scan_exp)), 32'd0);

    // Line 4: denominator below minimum behaves as 181.
    reg_denominator = 8'd100;
    run_line(4, 1, 24'h0, 1'b0, 2736);
    check("l4_pix1", 32'(pix[1]), 32'hE5E5E5);
    check("l4_pix2", 32'(pix[2]), 32'h1A1A1A);
    check("l4_pix639", 32'(pix[639]), 32'hFFFFFF);
    reg_denominator = 8'd200;

    // Vertical sync lines.
    vs_probe(490, 1'b1);
    vs_probe(491, 1'b0);
    vs_probe(492, 1'b0);
    vs_probe(493, 1'b1);

    // Mid-line reset forces reset values immediately.
    run_line(5, 1, 24'h0, 1'b0, 1000);
    check("mid_en_before", 32'(display_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_en", 32'(display_en), 32'd0);
    check("mid_rst_rgb", 32'({display_r, display_g, display_b}), 32'h0);
    check("mid_rst_hs", 32'(display_hs), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Line 6: resumes at the line start with fresh pos/frac.
    run_line(6, 1, 24'h0, 1'b0, 2736);
    check("l6_en_cnt", 32'(en_cnt), 32'd2560);
    check("l6_en_first", 32'(en_first), 32'd160);
    check("l6_pix1", 32'(pix[1]), 32'hE5E5E5);
    check("l6_pix2", 32'(pix[2]), 32'h323232);
    check("l6_pix639", 32'(pix[639]), 32'hFFFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
